posit_mult_arbiter_es3: RTL and testbench

- Shares one 4-stage raw ES3 posit multiplier (registered-input, fixed-latency, no stall, no reset) among NREQ requesters.
- Round-robin arbitration, one issue per cycle.
- Tracks the requester ID of each in-flight operation in a tag pipeline aligned to multiplier latency.
- Returns products through per-requester output FIFOs under credit-based flow control, so the non-stallable multiplier never overruns a destination.

---
 rtl/posit_mult_arbiter_es3.sv | 195 +++++++++++++++++++
 tb/tb_posit_mult_arbiter_es3.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mult_arbiter_es3.sv
// Round-robin, credit-flow-controlled sharing of one fixed-latency ES3 posit multiplier.
// Define POSIT_MULT_ARB_STATS_EN to add the issue / credit-stall statistics counters.
module posit_mult_arbiter_es3 #(
  parameter int NREQ                               = 2,
  parameter int LATENCY                            = 4,
  parameter int OUT_DEPTH                          = 2,
  parameter int POSIT_SERIALIZED_WIDTH_ES3         = 32,
  parameter int POSIT_SERIALIZED_WIDTH_PRODUCT_ES3 = 48
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic [NREQ-1:0]                                    req_valid,
  output logic [NREQ-1:0]                                    req_ready,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]         req_in1,
  input  logic [NREQ*POSIT_SERIALIZED_WIDTH_ES3-1:0]         req_in2,
  output logic [NREQ-1:0]                                    resp_valid,
  input  logic [NREQ-1:0]                                    resp_ready,
  output logic [NREQ*POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0] resp_result,
  output logic                                               mult_start,
  output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]              mult_in1,
  output logic [POSIT_SERIALIZED_WIDTH_ES3-1:0]              mult_in2,
  input  logic [POSIT_SERIALIZED_WIDTH_PRODUCT_ES3-1:0]      mult_result,
  input  logic                                               mult_done,
`ifdef POSIT_MULT_ARB_STATS_EN
  output logic [31:0]                                        stat_issued,
  output logic [31:0]                                        stat_credit_stall,
`endif
  output logic                                               tag_err
);

  localparam int OW = POSIT_SERIALIZED_WIDTH_ES3;
  localparam int RW = POSIT_SERIALIZED_WIDTH_PRODUCT_ES3;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int DW = $clog2(LATENCY + 1);

  logic [DW-1:0]    drain_q, drain_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    cnt_q [NREQ];
  logic             mult_start_q;
  logic [OW-1:0]    mult_in1_q, mult_in2_q;
  logic [LATENCY:0] tag_vld_q;
  logic [IW-1:0]    tag_id_q [LATENCY+1];
  logic             tag_err_q;
  logic [CW-1:0]    occ_q [NREQ];
  logic [AW-1:0]    rd_ptr_q [NREQ];
  logic [AW-1:0]    wr_ptr_q [NREQ];
  logic [RW-1:0]    mem_q [NREQ][OUT_DEPTH];

  logic            draining;
  logic [NREQ-1:0] elig, issue, pop, push;
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  int              arb_idx;
  logic            head_vld;
  logic [IW-1:0]   head_id;
  logic            push_req, overflow;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign draining = (drain_q != '0);
  assign head_vld = tag_vld_q[LATENCY];
  assign head_id  = tag_id_q[LATENCY];
  assign push_req = ~draining & mult_done & head_vld;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] & (cnt_q[i] < CW'(OUT_DEPTH)) & ~draining;
  end

  // First eligible requester at or after the round-robin pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(rr_q) + k) % NREQ;
      if (!grant_vld && elig[IW'(arb_idx)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(arb_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    issue     = '0;
    if (grant_vld) begin
      req_ready[grant_idx] = 1'b1;
      issue[grant_idx]     = 1'b1;
    end
  end

  always_comb begin
    rr_d    = rr_q;
    drain_d = drain_q;
    if (grant_vld) rr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    if (draining) drain_d = drain_q - 1'b1;
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is only an error without it.
  always_comb begin
    pop      = '0;
    push     = '0;
    overflow = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pop[i] = (occ_q[i] != '0) & resp_ready[i];
      if (push_req && head_id == IW'(i)) begin
        if (occ_q[i] < CW'(OUT_DEPTH) || pop[i]) push[i] = 1'b1;
        else overflow = 1'b1;
      end
    end
  end

  always_comb begin
    resp_valid  = '0;
    resp_result = '0;
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i]             = (occ_q[i] != '0);
      resp_result[i*RW +: RW]   = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_q      <= DW'(LATENCY);
      rr_q         <= '0;
      mult_start_q <= 1'b0;
      mult_in1_q   <= '0;
      mult_in2_q   <= '0;
      tag_vld_q    <= '0;
      tag_err_q    <= 1'b0;
      for (int i = 0; i <= LATENCY; i++) tag_id_q[i] <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt_q[i]    <= '0;
        occ_q[i]    <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
      end
    end else begin
      drain_q      <= drain_d;
      rr_q         <= rr_d;
      mult_start_q <= grant_vld;
      if (grant_vld) begin
        mult_in1_q <= req_in1[grant_idx*OW +: OW];
        mult_in2_q <= req_in2[grant_idx*OW +: OW];
      end
      tag_vld_q   <= {tag_vld_q[LATENCY-1:0], grant_vld};
      tag_id_q[0] <= grant_idx;
      for (int i = 1; i <= LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
      if ((~draining & (mult_done ^ head_vld)) | overflow) tag_err_q <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (issue[i] && !pop[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (!issue[i] && pop[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
        if (push[i] && !pop[i]) occ_q[i] <= occ_q[i] + 1'b1;
        else if (!push[i] && pop[i]) occ_q[i] <= occ_q[i] - 1'b1;
        if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
        if (pop[i]) rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= mult_result;
  end

  assign mult_start = mult_start_q;
  assign mult_in1   = mult_in1_q;
  assign mult_in2   = mult_in2_q;
  assign tag_err    = tag_err_q;

`ifdef POSIT_MULT_ARB_STATS_EN
  logic [31:0] stat_issued_q, stat_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      if (mult_start_q) stat_issued_q <= stat_issued_q + 1'b1;
      if ((|req_valid) && !draining && !grant_vld) stat_stall_q <= stat_stall_q + 1'b1;
    end
  end

  assign stat_issued       = stat_issued_q;
  assign stat_credit_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_posit_mult_arbiter_es3.sv
// Self-checking bench for posit_mult_arbiter_es3: bench emulates the multiplier and
// predicts grants/results from a queue-based credit/round-robin model.
`timescale 1ns/1ps
module tb_posit_mult_arbiter_es3;
  localparam int NREQ  = 2;
  localparam int LAT   = 4;
  localparam int DEPTH = 2;
  localparam int OW    = 32;
  localparam int RW    = 48;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*OW-1:0] req_in1 = '0;
  logic [NREQ*OW-1:0] req_in2 = '0;
  logic [NREQ-1:0]    resp_valid;
  logic [NREQ-1:0]    resp_ready = '0;
  logic [NREQ*RW-1:0] resp_result;
  logic               mult_start;
  logic [OW-1:0]      mult_in1, mult_in2;
  logic [RW-1:0]      mult_result;
  logic               mult_done;
  logic               tag_err;
  logic               force_done = 1'b0;

  logic [LAT-1:0] pv = '0;
  logic [RW-1:0]  pd [LAT];

  int errors = 0;
  int checks = 0;

  typedef struct packed { int id; logic [RW-1:0] res; int due; } op_t;
  op_t           pend[$];
  logic [RW-1:0] fq [NREQ][$];
  int            m_cyc = 0;
  int            m_rr = 0;
  int            m_drain = LAT;
  logic          m_tag_err = 1'b0;
  logic          m_start = 1'b0;
  logic [NREQ-1:0] obs_rdy;

  always #5 clk = ~clk;

  posit_mult_arbiter_es3 #(
    .NREQ(NREQ), .LATENCY(LAT), .OUT_DEPTH(DEPTH),
    .POSIT_SERIALIZED_WIDTH_ES3(OW), .POSIT_SERIALIZED_WIDTH_PRODUCT_ES3(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .mult_start(mult_start), .mult_in1(mult_in1), .mult_in2(mult_in2),
    .mult_result(mult_result), .mult_done(mult_done),
    .tag_err(tag_err)
  );

  function automatic logic [RW-1:0] prod(input logic [OW-1:0] a, input logic [OW-1:0] b);
    logic [2*OW-1:0] p;
    p = (2*OW)'(a) * (2*OW)'(b);
    return p[RW-1:0];
  endfunction

  // Unresettable fixed-latency multiplier stand-in.
  always @(posedge clk) begin
    pv    <= {pv[LAT-2:0], mult_start};
    pd[0] <= prod(mult_in1, mult_in2);
    for (int k = 1; k < LAT; k++) pd[k] <= pd[k-1];
  end
  assign mult_done   = pv[LAT-1] | force_done;
  assign mult_result = pd[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int credits(input int i);
    int c;
    c = fq[i].size();
    foreach (pend[k]) if (pend[k].id == i) c++;
    return c;
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_in1[i*OW +: OW] = $urandom;
      req_in2[i*OW +: OW] = $urandom;
    end
  endtask

  // Called mid-cycle with inputs already driven; checks this cycle, advances the model, returns next mid-cycle.
  task automatic step(output int g);
    logic [NREQ-1:0] exp_rdy, exp_rv;
    int cand;
    op_t o;
    g = -1;
    #1;
    obs_rdy = req_ready;
    if (m_drain == 0)
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_rr + k) % NREQ;
        if (g < 0 && req_valid[cand] && credits(cand) < DEPTH) g = cand;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy = NREQ'(1) << g;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("mult_start", 64'(mult_start), 64'(m_start));
    exp_rv = '0;
    for (int i = 0; i < NREQ; i++) exp_rv[i] = (fq[i].size() != 0);
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    for (int i = 0; i < NREQ; i++)
      if (fq[i].size() != 0) chk("resp_result", 64'(resp_result[i*RW +: RW]), 64'(fq[i][0]));
    chk("tag_err", 64'(tag_err), 64'(m_tag_err));
    for (int i = 0; i < NREQ; i++)
      if (exp_rv[i] && resp_ready[i]) void'(fq[i].pop_front());
    if (pend.size() != 0 && pend[0].due == m_cyc) begin
      fq[pend[0].id].push_back(pend[0].res);
      void'(pend.pop_front());
    end else if (force_done && m_drain == 0) begin
      m_tag_err = 1'b1;
    end
    if (g >= 0) begin
      o.id  = g;
      o.res = prod(req_in1[g*OW +: OW], req_in2[g*OW +: OW]);
      o.due = m_cyc + 1 + LAT;
      pend.push_back(o);
      m_rr = (g + 1) % NREQ;
    end
    m_start = (g >= 0);
    if (m_drain > 0) m_drain--;
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    force_done = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_tag_err", 64'(tag_err), 64'(0));
    chk("rst_mult_start", 64'(mult_start), 64'(0));
    chk("rst_mult_in1", 64'(mult_in1), 64'(0));
    chk("rst_mult_in2", 64'(mult_in2), 64'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pend.delete();
    for (int i = 0; i < NREQ; i++) fq[i].delete();
    m_rr = 0;
    m_drain = LAT;
    m_tag_err = 1'b0;
    m_start = 1'b0;
    m_cyc++;
  endtask

  initial begin
    int g, first, n1, n;
    logic [OW-1:0] a;
    #2;
    do_reset();
    repeat (6) step(g);

    // Single requester 0, uncontended latency.
    a = 32'h0100_0003;
    resp_ready = '1;
    req_valid = 2'b01;
    req_in1[0 +: OW] = a;
    req_in2[0 +: OW] = a;
    step(g);
    req_valid = '0;
    #1;
    chk("start_after_accept", 64'(mult_start), 64'(1));
    chk("in1_after_accept", 64'(mult_in1), 64'(a));
    chk("in2_after_accept", 64'(mult_in2), 64'(a));
    first = -1;
    for (int k = 1; k <= 10; k++) begin
      if (first < 0 && resp_valid[0]) first = k;
      step(g);
    end
    chk("single_latency", 64'(first), 64'(LAT + 2));

    // Random requests, consumers always ready.
    repeat (200) begin
      req_valid = NREQ'($urandom);
      rand_ops();
      step(g);
    end

    // Drain, then starve requester 1's consumer.
    req_valid = '0;
    repeat (12) step(g);
    req_valid = '1;
    resp_ready = 2'b01;
    n1 = 0;
    repeat (30) begin
      rand_ops();
      step(g);
      n1 += int'(obs_rdy[1]);
    end
    chk("bp_grants_req1", 64'(n1), 64'(DEPTH));
    resp_ready = '1;
    n1 = 0;
    repeat (20) begin
      rand_ops();
      step(g);
      n1 += int'(obs_rdy[1]);
    end
    chk("bp_resume_req1", 64'(n1 > 0), 64'(1));

    // Random requests and random consumer readiness.
    repeat (300) begin
      req_valid = NREQ'($urandom);
      resp_ready = NREQ'($urandom);
      rand_ops();
      step(g);
    end

    // Reset with operations in flight.
    req_valid = '1;
    resp_ready = '1;
    for (int k = 0; k < 20 && pend.size() < 3; k++) begin
      rand_ops();
      step(g);
    end
    chk("ops_in_flight", 64'(pend.size() >= 3), 64'(1));
    do_reset();
    n = 0;
    repeat (LAT) begin
      rand_ops();
      step(g);
      n += $countones(obs_rdy);
    end
    chk("drain_no_ready", 64'(n), 64'(0));
    repeat (20) begin
      rand_ops();
      step(g);
    end

    // Spurious mult_done with an empty tag head.
    req_valid = '0;
    repeat (14) step(g);
    force_done = 1'b1;
    step(g);
    force_done = 1'b0;
    chk("tag_err_set", 64'(tag_err), 64'(1));
    repeat (5) step(g);
    chk("tag_err_sticky", 64'(tag_err), 64'(1));
    do_reset();
    repeat (LAT + 2) step(g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
